// File: rtl/bip_control_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : bip_control_if                                                 |
// | Purpose   : Bundles the BIP controller's program-memory fetch path,        |
// |             datapath control strobes and status outputs.                   |
// | Modports  : slave  - the controller (consumes run/instr, drives the rest)   |
// |             master - the datapath/environment side                         |
// | Signals   : run, instr[15:0], pc[PC_WIDTH-1:0], operand[10:0], imm[15:0],  |
// |             op, sel_a[1:0], sel_b, wr_acc, wr_ram, rd_ram, halted,         |
// |             instr_count[15:0]                                              |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface bip_control_if #(
  parameter int PC_WIDTH = 11
);
  logic                run;
  logic [15:0]         instr;
  logic [PC_WIDTH-1:0] pc;
  logic [10:0]         operand;
  logic [15:0]         imm;
  logic                op;
  logic [1:0]          sel_a;
  logic                sel_b;
  logic                wr_acc;
  logic                wr_ram;
  logic                rd_ram;
  logic                halted;
  logic [15:0]         instr_count;

  modport slave (
    input  run, instr,
    output pc, operand, imm, op, sel_a, sel_b,
           wr_acc, wr_ram, rd_ram, halted, instr_count
  );

  modport master (
    output run, instr,
    input  pc, operand, imm, op, sel_a, sel_b,
           wr_acc, wr_ram, rd_ram, halted, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/bip_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : bip_control                                                    |
// | Purpose   : Control unit of a Basic Instruction Processor. Three-state     |
// |             FETCH/EXEC/HALT machine that fetches a 16-bit instruction,     |
// |             decodes its 5-bit opcode into datapath strobes for one cycle,  |
// |             advances the PC and counts retired instructions.              |
// | Ports     : clk   - rising-edge clock                                      |
// |             rst_n - asynchronous active-low reset                          |
// |             bus   - bip_control_if.slave (fetch path, strobes, status)     |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module bip_control #(
  parameter int          PC_WIDTH = 11,
  parameter int unsigned RESET_PC = 0
) (
  input wire             clk,
  input wire             rst_n,
  bip_control_if.slave   bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);

  state_e              state_q;
  logic [15:0]         ir_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic [15:0]         count_q;
  logic [15:0]         count_d;
  logic                halted_q;

  logic                op_w;
  logic [1:0]          sel_a_w;
  logic                sel_b_w;
  logic                wr_acc_w;
  logic                wr_ram_w;
  logic                rd_ram_w;

  // PC wraps naturally at 2^PC_WIDTH; the retire counter sticks at all-ones.
  assign pc_d    = pc_q + PC_WIDTH'(1);
  assign count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      ir_q     <= 16'h0000;
      pc_q     <= RESET_PC_V;
      count_q  <= 16'h0000;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (bus.run) begin
            ir_q    <= bus.instr;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (ir_q[15:11] == OP_HLT) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else begin
            // Every non-HLT opcode retires, including undefined ones (NOP).
            pc_q    <= pc_d;
            count_q <= count_d;
            state_q <= FETCH;
          end
        end
        HALT: begin
          // Absorbing: only the asynchronous reset leaves this state.
          state_q <= HALT;
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  // Strobes are decoded straight from IR and state so that an asynchronous
  // reset landing in EXEC removes them without waiting for a clock edge.
  always_comb begin
    op_w     = 1'b0;
    sel_a_w  = 2'b00;
    sel_b_w  = 1'b0;
    wr_acc_w = 1'b0;
    wr_ram_w = 1'b0;
    rd_ram_w = 1'b0;
    if (state_q == EXEC) begin
      case (ir_q[15:11])
        OP_STO: begin
          wr_ram_w = 1'b1;
        end
        OP_LD: begin
          rd_ram_w = 1'b1;
          wr_acc_w = 1'b1;
          sel_a_w  = 2'b00;
        end
        OP_LDI: begin
          wr_acc_w = 1'b1;
          sel_a_w  = 2'b01;
        end
        OP_ADD, OP_SUB: begin
          rd_ram_w = 1'b1;
          wr_acc_w = 1'b1;
          sel_a_w  = 2'b10;
          sel_b_w  = 1'b0;
          op_w     = ir_q[12];
        end
        OP_ADDI, OP_SUBI: begin
          wr_acc_w = 1'b1;
          sel_a_w  = 2'b10;
          sel_b_w  = 1'b1;
          op_w     = ir_q[12];
        end
        default: begin
          // HLT and undefined opcodes drive no strobes.
        end
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.operand     = ir_q[10:0];
  assign bus.imm         = {{5{ir_q[10]}}, ir_q[10:0]};
  assign bus.op          = op_w;
  assign bus.sel_a       = sel_a_w;
  assign bus.sel_b       = sel_b_w;
  assign bus.wr_acc      = wr_acc_w;
  assign bus.wr_ram      = wr_ram_w;
  assign bus.rd_ram      = rd_ram_w;
  assign bus.halted      = halted_q;
  assign bus.instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_bip_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_bip_control                                                 |
// | Purpose   : Scoreboard bench for bip_control. Stimulus pushes the expected |
// |             strobe/select snapshot of each strobing instruction; a monitor |
// |             pops and compares whenever the DUT asserts any strobe. Direct  |
// |             checks cover reset, pc/instr_count, halting and the wrap case. |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_bip_control;

  typedef struct packed {
    logic        wr_acc;
    logic        wr_ram;
    logic        rd_ram;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        op;
    logic [15:0] imm;
    logic [10:0] operand;
    logic [10:0] pc;
  } exp_t;

  logic clk;
  logic rst_n;
  logic rst2_n;

  bip_control_if #(.PC_WIDTH(11)) if_a ();
  bip_control_if #(.PC_WIDTH(11)) if_b ();

  logic [15:0] mem_a [0:2047];
  logic [15:0] mem_b [0:2047];

  assign if_a.instr = mem_a[if_a.pc];
  assign if_b.instr = mem_b[if_b.pc];

  bip_control #(.PC_WIDTH(11), .RESET_PC(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  bip_control #(.PC_WIDTH(11), .RESET_PC(2047)) dut_wrap (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (if_b)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic wa, input logic wr, input logic rr,
                              input logic [1:0] sa, input logic sb, input logic o,
                              input logic [15:0] im, input logic [10:0] opd,
                              input logic [10:0] p);
    exp_t e;
    e = '{wr_acc: wa, wr_ram: wr, rd_ram: rr, sel_a: sa, sel_b: sb, op: o,
          imm: im, operand: opd, pc: p};
    return e;
  endfunction

  // Monitor: any asserted strobe is a DUT output event to be scored.
  always @(negedge clk) begin
    exp_t act;
    exp_t e;
    if (rst_n && (if_a.wr_acc || if_a.wr_ram || if_a.rd_ram)) begin
      act = '{wr_acc: if_a.wr_acc, wr_ram: if_a.wr_ram, rd_ram: if_a.rd_ram,
              sel_a: if_a.sel_a, sel_b: if_a.sel_b, op: if_a.op,
              imm: if_a.imm, operand: if_a.operand, pc: if_a.pc};
      if (sb_q.size() == 0) begin
        chk("unexpected_strobe", 64'(act), 64'(0));
      end else begin
        e = sb_q.pop_front();
        chk("sb_exec", 64'(act), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

  function automatic logic [2:0] strb_a();
    return {if_a.wr_acc, if_a.wr_ram, if_a.rd_ram};
  endfunction

  task automatic wait_halt_a(input int max, output int n);
    n = 0;
    while (!if_a.halted && n < max) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_pc_a(input logic [10:0] p, input int max);
    int n;
    n = 0;
    while (if_a.pc !== p && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_pc_reached", 64'(if_a.pc), 64'(p));
  endtask

  task automatic clear_mem_a();
    for (int i = 0; i < 2048; i++) mem_a[i] = 16'h0000;
  endtask

  initial begin
    int   n;
    logic seen;

    rst_n     = 1'b0;
    rst2_n    = 1'b0;
    if_a.run  = 1'b0;
    if_b.run  = 1'b0;
    clear_mem_a();
    for (int i = 0; i < 2048; i++) mem_b[i] = 16'h0000;

    // ---------------- Reset state (clock running, reset held) -------------
    repeat (3) @(negedge clk);
    chk("rst_pc",      64'(if_a.pc), 64'(0));
    chk("rst_count",   64'(if_a.instr_count), 64'(0));
    chk("rst_halted",  64'(if_a.halted), 64'(0));
    chk("rst_strobes", 64'({strb_a(), if_a.sel_a, if_a.sel_b, if_a.op}), 64'(0));
    chk("rst_operand", 64'(if_a.operand), 64'(0));

    // ---------------- Program A: LDI 5, ADDI 3, HLT ------------------------
    mem_a[0] = 16'h1805;
    mem_a[1] = 16'h2803;
    mem_a[2] = 16'h0000;
    sb_q.push_back(mk(1, 0, 0, 2'b01, 0, 0, 16'h0005, 11'h005, 11'd0));
    sb_q.push_back(mk(1, 0, 0, 2'b10, 1, 0, 16'h0003, 11'h003, 11'd1));
    @(negedge clk);
    rst_n    = 1'b1;
    if_a.run = 1'b1;
    wait_halt_a(50, n);
    chk("progA_halt_cycles", 64'(n), 64'(6));
    chk("progA_pc",     64'(if_a.pc), 64'(2));
    chk("progA_count",  64'(if_a.instr_count), 64'(2));
    repeat (5) @(negedge clk);
    chk("halt_absorb", 64'({if_a.halted, if_a.pc, if_a.instr_count}),
        64'({1'b1, 11'd2, 16'd2}));
    chk("progA_sb_empty", 64'(sb_q.size()), 64'(0));

    // ---------------- Program B: decode table, run pause, NOPs -------------
    @(negedge clk);
    rst_n    = 1'b0;
    if_a.run = 1'b0;
    clear_mem_a();
    mem_a[0] = 16'h3FFF;  // SUBI -1
    mem_a[1] = 16'h0812;  // STO 0x012
    mem_a[2] = 16'h1007;  // LD 7
    mem_a[3] = 16'h2005;  // ADD 5
    mem_a[4] = 16'h3010;  // SUB 0x10
    mem_a[5] = 16'hF800;  // NOP
    mem_a[6] = 16'h4400;  // NOP (opcode 01000)
    mem_a[7] = 16'h0000;  // HLT
    sb_q.push_back(mk(1, 0, 0, 2'b10, 1, 1, 16'hFFFF, 11'h7FF, 11'd0));
    sb_q.push_back(mk(0, 1, 0, 2'b00, 0, 0, 16'h0012, 11'h012, 11'd1));
    sb_q.push_back(mk(1, 0, 1, 2'b00, 0, 0, 16'h0007, 11'h007, 11'd2));
    sb_q.push_back(mk(1, 0, 1, 2'b10, 0, 0, 16'h0005, 11'h005, 11'd3));
    sb_q.push_back(mk(1, 0, 1, 2'b10, 0, 1, 16'h0010, 11'h010, 11'd4));
    @(negedge clk);
    chk("rst2_halted_clear", 64'(if_a.halted), 64'(0));
    rst_n    = 1'b1;
    if_a.run = 1'b1;
    wait_pc_a(11'd3, 40);
    @(negedge clk);
    if_a.run = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (strb_a() != 3'b000 || if_a.pc !== 11'd3) seen = 1'b1;
    end
    chk("pause_quiet", 64'(seen), 64'(0));
    chk("pause_pc_count", 64'({if_a.pc, if_a.instr_count}), 64'({11'd3, 16'd3}));
    if_a.run = 1'b1;
    @(posedge clk); #1;
    chk("resume_add_strobes", 64'(strb_a()), 64'(3'b101));
    wait_halt_a(40, n);
    chk("progB_halted", 64'(if_a.halted), 64'(1));
    chk("progB_pc_count", 64'({if_a.pc, if_a.instr_count}), 64'({11'd7, 16'd7}));
    chk("progB_nop_imm", 64'(if_a.imm), 64'(16'h0000));
    chk("progB_sb_empty", 64'(sb_q.size()), 64'(0));

    // ---------------- Program C: reset mid-EXEC of ADD ---------------------
    @(negedge clk);
    rst_n    = 1'b0;
    if_a.run = 1'b0;
    clear_mem_a();
    mem_a[0] = 16'h1805;  // LDI 5
    mem_a[1] = 16'h2005;  // ADD 5
    sb_q.push_back(mk(1, 0, 0, 2'b01, 0, 0, 16'h0005, 11'h005, 11'd0));
    @(negedge clk);
    rst_n    = 1'b1;
    if_a.run = 1'b1;
    wait_pc_a(11'd1, 20);
    @(posedge clk); #1;
    chk("add_exec_strobes", 64'(strb_a()), 64'(3'b101));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_drop_strobes",
        64'({strb_a(), if_a.sel_a, if_a.sel_b, if_a.op}), 64'(0));
    chk("async_pc_count", 64'({if_a.pc, if_a.instr_count}), 64'(0));
    chk("progC_sb_empty", 64'(sb_q.size()), 64'(0));
    @(negedge clk);
    if_a.run = 1'b0;

    // ---------------- Wrap: RESET_PC=2047, NOP then HLT --------------------
    mem_b[2047] = 16'hF800;
    mem_b[0]    = 16'h0000;
    @(negedge clk);
    chk("wrap_rst_pc", 64'(if_b.pc), 64'(2047));
    rst2_n   = 1'b1;
    if_b.run = 1'b1;
    seen = 1'b0;
    n = 0;
    while (!if_b.halted && n < 30) begin
      @(posedge clk); #1;
      n++;
      if ({if_b.wr_acc, if_b.wr_ram, if_b.rd_ram} != 3'b000) seen = 1'b1;
    end
    chk("wrap_halted", 64'(if_b.halted), 64'(1));
    chk("wrap_pc_count", 64'({if_b.pc, if_b.instr_count}), 64'({11'd0, 16'd1}));
    chk("wrap_no_strobes", 64'(seen), 64'(0));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
